// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-organised data memory for the single-cycle RISC-V MEM stage
//
// Purpose: DEPTH x 32-bit word store with a synchronous write and a combinational,
// zero-latency read. The address is a word index, not a byte address. Any index
// at or above DEPTH is out of range: writes there are dropped and reads return zero.
//
// Ports:
//   clk        in   1   rising-edge clock for every state update
//   reset      in   1   synchronous active-high reset; clears every word; beats MemWrite
//   MemRead    in   1   read enable; read_data is zero while low
//   MemWrite   in   1   write enable, sampled at the rising clk edge
//   address    in  32   word index
//   write_data in  32   word stored on a qualified write
//   read_data  out 32   combinational read result (no output register)

module data_memory #(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    logic [31:0]   mem_q [DEPTH];
    logic          addr_valid;
    logic [AW-1:0] word_idx;
    logic          wr_en_d;

    // An access is in range only when every bit above the index field is zero.
    // Taking just the low AW bits alone would alias out-of-range addresses onto
    // real words.
    assign addr_valid = (address[31:AW] == '0);
    assign word_idx   = address[AW-1:0];
    assign wr_en_d    = MemWrite && addr_valid;

    // Reset is checked first, so a write presented in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[word_idx] <= write_data;
        end
    end

    // The read comes straight from the array and never bypasses write_data. On a
    // same-address read/write, read_data shows the old word until the edge and the
    // new word after it.
    assign read_data = (MemRead && addr_valid) ? mem_q[word_idx] : 32'h0000_0000;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory

module tb_data_memory;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    string       tag_q [$];
    int          total = 0;
    int          bad = 0;

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [31:0] v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk();
        logic [31:0] e;
        string       t;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (read_data === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, read_data, e);
        end
    endtask

    // Drive a read and check it against the bench's model of the memory contents.
    task automatic rd_model(input logic [31:0] a, input logic mr, input string tag);
        address = a;
        MemRead = mr;
        push_exp((mr && a < DEPTH) ? model[a[5:0]] : 32'h0, tag);
        pop_chk();
    endtask

    // Drive a read and check it against a fixed value.
    task automatic rd_const(input logic [31:0] a, input logic mr, input logic [31:0] v,
                            input string tag);
        address = a;
        MemRead = mr;
        push_exp(v, tag);
        pop_chk();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemRead    = 1'b0;
        MemWrite   = 1'b1;
        address    = a;
        write_data = d;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        if (!reset && a < DEPTH) model[a[5:0]] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        @(posedge clk);
        do_reset();

        // Contents after reset
        rd_const(32'd2, 1'b1, 32'h0000_0000, "reset_rd_a2");
        rd_const(32'd0, 1'b1, 32'h0000_0000, "reset_rd_a0");
        rd_const(32'd63, 1'b1, 32'h0000_0000, "reset_rd_a63");

        // Write then readback
        wr(32'd7, 32'h16CD_EFFF);
        rd_const(32'd7, 1'b1, 32'h16CD_EFFF, "wr_rd_a7");
        rd_const(32'd3, 1'b1, 32'h0000_0000, "rd_a3_untouched");

        // Read gating: a raised MemRead must show the word in the same timestep
        rd_const(32'd7, 1'b0, 32'h0000_0000, "gate_off_a7");
        rd_const(32'd7, 1'b1, 32'h16CD_EFFF, "gate_on_a7");

        // Simultaneous read and write to address 5
        wr(32'd5, 32'hAAAA_0001);
        MemWrite   = 1'b1;
        write_data = 32'h5555_BEEF;
        rd_const(32'd5, 1'b1, 32'hAAAA_0001, "rw_before_edge");
        @(posedge clk);
        model[5] = 32'h5555_BEEF;
        push_exp(32'h5555_BEEF, "rw_after_edge");
        pop_chk();
        MemWrite = 1'b0;

        // Out-of-range accesses must not alias onto real words
        wr(32'd0, 32'h00C0_FFEE);
        wr(32'd64, 32'hDEAD_BEEF);
        wr(32'h8000_0001, 32'hBAD0_0001);
        wr(32'd65, 32'hBAD0_0065);
        rd_const(32'd0, 1'b1, 32'h00C0_FFEE, "oor_wr_keeps_a0");
        rd_const(32'd1, 1'b1, 32'h0000_0000, "oor_wr_keeps_a1");
        rd_const(32'd64, 1'b1, 32'h0000_0000, "oor_rd_a64");
        rd_const(32'h8000_0001, 1'b1, 32'h0000_0000, "oor_rd_hibit");

        // Top word and a batch of pattern writes checked against the model
        wr(32'd63, 32'hFFFF_FFFF);
        rd_const(32'd63, 1'b1, 32'hFFFF_FFFF, "top_word");
        for (int i = 0; i < 8; i++) begin
            wr(32'(i * 7 + 10), $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            rd_model(32'(i * 7 + 10), 1'b1, "pattern_rd");
        end
        rd_model(32'd17, 1'b0, "pattern_gated");

        // Reset takes priority over a write on the same edge
        reset      = 1'b1;
        MemWrite   = 1'b1;
        address    = 32'd4;
        write_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        MemWrite = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        rd_const(32'd4, 1'b1, 32'h0000_0000, "reset_prio_a4");
        rd_const(32'd7, 1'b1, 32'h0000_0000, "reset_clears_a7");
        rd_const(32'd63, 1'b1, 32'h0000_0000, "reset_clears_a63");
        rd_model(32'd10, 1'b1, "reset_clears_model");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
